// File: rtl/jk_fsm_bank.sv
// jk_fsm_bank: bank of independent j/k two-state channels with per-channel dwell counters
module jk_fsm_bank #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_DWELL = 0
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NCH-1:0]       j,
  input  logic [NCH-1:0]       k,
  output logic [NCH-1:0]       out,
  output logic [NCH-1:0]       rise,
  output logic [NCH-1:0]       fall,
  output logic [NCH*CNT_W-1:0] dwell,
  output logic                 any_on
);
  typedef enum logic {st_a, st_b} state_t;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             ok, go, r, f;
    if (MIN_DWELL == 0) begin : g_nomin
      assign ok = 1'b1;
    end else begin : g_min
      assign ok = cnt >= CNT_W'(MIN_DWELL);
    end
    assign go = ok && (st == st_a ? j[i] : k[i]);
    always_ff @(posedge clk or negedge areset_n)
      if (!areset_n) begin
        st  <= st_a;
        cnt <= '0;
        r   <= 1'b0;
        f   <= 1'b0;
      end else if (clr) begin
        st  <= st_a;
        cnt <= '0;
        r   <= 1'b0;
        f   <= 1'b0;
      end else if (!en) begin
        r <= 1'b0;
        f <= 1'b0;
      end else begin
        st  <= go ? (st == st_a ? st_b : st_a) : st;
        cnt <= go ? '0 : cnt + CNT_W'(cnt != '1);
        r   <= go && st == st_a;
        f   <= go && st == st_b;
      end
    assign out[i]                   = st == st_b;
    assign rise[i]                  = r;
    assign fall[i]                  = f;
    assign dwell[i*CNT_W +: CNT_W]  = cnt;
  end
  assign any_on = |out;
endmodule

// File: tb/tb_jk_fsm_bank.sv
// tb_jk_fsm_bank: two banks (MIN_DWELL 0 and 3) checked against a reference model and vector table
module tb_jk_fsm_bank;
  logic clk = 0, areset_n = 1, en = 0, clr = 0;
  logic [3:0] j = 0, k = 0;
  logic [3:0] out0, rise0, fall0, out3, rise3, fall3;
  logic [15:0] dw0, dw3;
  logic any0, any3;

  always #5 clk = ~clk;

  jk_fsm_bank #(.NCH(4), .CNT_W(4), .MIN_DWELL(0)) dut0 (
    .clk(clk), .areset_n(areset_n), .en(en), .clr(clr), .j(j), .k(k),
    .out(out0), .rise(rise0), .fall(fall0), .dwell(dw0), .any_on(any0));
  jk_fsm_bank #(.NCH(4), .CNT_W(4), .MIN_DWELL(3)) dut3 (
    .clk(clk), .areset_n(areset_n), .en(en), .clr(clr), .j(j), .k(k),
    .out(out3), .rise(rise3), .fall(fall3), .dwell(dw3), .any_on(any3));

  typedef struct packed {
    logic [3:0]  o, r, f;
    logic [15:0] d;
    logic        a;
  } obs_t;

  typedef struct {
    logic       e, c;
    logic [3:0] jj, kk, eo, er, ef;
  } vec_t;

  obs_t q[$];
  int tests = 0, fails = 0;
  int mst[2][4], mcnt[2][4], mr[2][4], mf[2][4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t model_obs(input int d);
    obs_t o = '0;
    for (int c = 0; c < 4; c++) begin
      o.o[c] = mst[d][c] != 0;
      o.r[c] = mr[d][c] != 0;
      o.f[c] = mf[d][c] != 0;
      o.d[c*4 +: 4] = 4'(mcnt[d][c]);
    end
    o.a = |o.o;
    return o;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        mst[d][c] = 0; mcnt[d][c] = 0; mr[d][c] = 0; mf[d][c] = 0;
      end
  endtask

  task automatic step(input logic e, input logic c, input logic [3:0] jj, input logic [3:0] kk);
    obs_t e0, e3;
    en = e; clr = c; j = jj; k = kk;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 4; ch++) begin
        int md = d ? 3 : 0;
        if (c) begin
          mst[d][ch] = 0; mcnt[d][ch] = 0; mr[d][ch] = 0; mf[d][ch] = 0;
        end else if (!e) begin
          mr[d][ch] = 0; mf[d][ch] = 0;
        end else if ((mst[d][ch] ? kk[ch] : jj[ch]) && mcnt[d][ch] >= md) begin
          mr[d][ch] = 1 - mst[d][ch];
          mf[d][ch] = mst[d][ch];
          mst[d][ch] = 1 - mst[d][ch];
          mcnt[d][ch] = 0;
        end else begin
          mr[d][ch] = 0; mf[d][ch] = 0;
          if (mcnt[d][ch] < 15) mcnt[d][ch]++;
        end
      end
    q.push_back(model_obs(0));
    q.push_back(model_obs(1));
    @(posedge clk); #1;
    e0 = q.pop_front();
    e3 = q.pop_front();
    check("sb_dut0", {out0, rise0, fall0, dw0, any0}, e0);
    check("sb_dut3", {out3, rise3, fall3, dw3, any3}, e3);
  endtask

  // Asserted between edges; outputs must drop without any clock.
  task automatic do_areset();
    en = 0; clr = 0; j = 0; k = 0;
    areset_n = 0;
    #1;
    model_clear();
    check("areset_dut0", {out0, rise0, fall0, dw0, any0}, 0);
    check("areset_dut3", {out3, rise3, fall3, dw3, any3}, 0);
    #2 areset_n = 1;
  endtask

  vec_t tbl[10];
  int n;

  initial begin
    tbl[0] = '{1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0101, 4'b0000};
    tbl[1] = '{1, 0, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
    tbl[2] = '{1, 0, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0001};
    tbl[3] = '{1, 0, 4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0000};
    tbl[4] = '{1, 0, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0001};
    tbl[5] = '{0, 0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    tbl[6] = '{1, 0, 4'b1010, 4'b0100, 4'b1010, 4'b1010, 4'b0100};
    tbl[7] = '{1, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[8] = '{1, 0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    tbl[9] = '{1, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111};

    @(posedge clk); #1;
    do_areset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].e, tbl[i].c, tbl[i].jj, tbl[i].kk);
      check($sformatf("vec%0d", i), {out0, rise0, fall0, any0},
            {tbl[i].eo, tbl[i].er, tbl[i].ef, |tbl[i].eo});
    end

    // dwell saturation, then frozen by en=0
    do_areset();
    repeat (20) step(1, 0, 4'h0, 4'h0);
    check("sat_dw0", dw0, 16'hffff);
    check("sat_dw3", dw3, 16'hffff);
    repeat (5) step(0, 0, 4'hF, 4'h0);
    check("frz_dw0", dw0, 16'hffff);
    check("frz_out", {out0, out3}, 8'h00);

    // async reset mid-operation, no pulses after release
    step(1, 0, 4'b1010, 4'b0000);
    check("pre_rst_out", {out0, out3}, 8'b1010_1010);
    do_areset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'h0, 4'h0);
      check("post_rst_pulse", {rise0, fall0, rise3, fall3}, 16'h0);
    end

    // minimum dwell gating on channel 1
    do_areset();
    repeat (3) step(1, 0, 4'h0, 4'h0);
    step(1, 0, 4'b0010, 4'b0000);
    check("md_enter", {out3[1], rise3[1]}, 2'b11);
    n = 0;
    while (out3[1] && n < 8) begin
      step(1, 0, 4'h0, 4'b0010);
      n++;
    end
    check("md_edges", n, 4);
    check("md_fall", fall3[1], 1'b1);

    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
